// File: rtl/top_control_if.sv
// top_control_if: decoder bus carrying the instruction fields in and the
// registered datapath control strobes out.
interface top_control_if;
    logic [6:0] Opcode;
    logic [3:0] Funct;
    logic       Branch;
    logic       MemRead;
    logic       MemtoReg;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic [3:0] Operation;
    logic       Illegal;

    // Instruction source side: drives the fields, observes the strobes
    modport master (
        output Opcode, Funct,
        input  Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
               Operation, Illegal
    );

    // Decoder side: consumes the fields, drives the strobes
    modport slave (
        input  Opcode, Funct,
        output Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
               Operation, Illegal
    );
endinterface

// File: rtl/top_control.sv
// top_control: main control decoder plus ALU control for the single-cycle
// RV core. Combinational decode feeding one output register stage.
// Optional feature macro: TOP_CONTROL_ITYPE_EN adds I-type ALU decode
// (opcode 0010011, internal ALUOp 11).
module top_control (
    input  logic         clk,
    input  logic         rst_n,
    top_control_if.slave ctl
);
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef TOP_CONTROL_ITYPE_EN
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
`endif

    logic       branch_d;
    logic       mem_read_d;
    logic       mem_to_reg_d;
    logic       mem_write_d;
    logic       alu_src_d;
    logic       reg_write_d;
    logic       illegal_d;
    logic [1:0] alu_op;
    logic [3:0] operation_d;

    // Main decoder: opcode -> control strobes and ALU-op class
    always_comb begin
        branch_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        illegal_d    = 1'b0;
        alu_op       = 2'b00;
        case (ctl.Opcode)
            OP_RTYPE: begin
                reg_write_d = 1'b1;
                alu_op      = 2'b10;
            end
            OP_LOAD: begin
                mem_read_d   = 1'b1;
                mem_to_reg_d = 1'b1;
                alu_src_d    = 1'b1;
                reg_write_d  = 1'b1;
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
            end
            OP_BRANCH: begin
                branch_d = 1'b1;
                alu_op   = 2'b01;
            end
`ifdef TOP_CONTROL_ITYPE_EN
            OP_ITYPE: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op      = 2'b11;
            end
`endif
            default: illegal_d = 1'b1;
        endcase
    end

    // ALU control: ALU-op class and Funct -> 4-bit operation, zero when illegal
    always_comb begin
        operation_d = 4'b0010;
        case (alu_op)
            2'b00: operation_d = 4'b0010;
            2'b01: operation_d = 4'b0110;
            2'b10: begin
                case (ctl.Funct)
                    4'b0000: operation_d = 4'b0010;
                    4'b1000: operation_d = 4'b0110;
                    4'b0111: operation_d = 4'b0000;
                    4'b0110: operation_d = 4'b0001;
                    default: operation_d = 4'b0010;
                endcase
            end
`ifdef TOP_CONTROL_ITYPE_EN
            2'b11: begin
                case (ctl.Funct[2:0])
                    3'b000:  operation_d = 4'b0010;
                    3'b111:  operation_d = 4'b0000;
                    3'b110:  operation_d = 4'b0001;
                    default: operation_d = 4'b0010;
                endcase
            end
`endif
            default: operation_d = 4'b0010;
        endcase
        if (illegal_d) begin
            operation_d = 4'b0000;
        end
    end

    // Output register: one cycle of latency, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl.Branch    <= 1'b0;
            ctl.MemRead   <= 1'b0;
            ctl.MemtoReg  <= 1'b0;
            ctl.MemWrite  <= 1'b0;
            ctl.ALUSrc    <= 1'b0;
            ctl.RegWrite  <= 1'b0;
            ctl.Operation <= '0;
            ctl.Illegal   <= 1'b0;
        end else begin
            ctl.Branch    <= branch_d;
            ctl.MemRead   <= mem_read_d;
            ctl.MemtoReg  <= mem_to_reg_d;
            ctl.MemWrite  <= mem_write_d;
            ctl.ALUSrc    <= alu_src_d;
            ctl.RegWrite  <= reg_write_d;
            ctl.Operation <= operation_d;
            ctl.Illegal   <= illegal_d;
        end
    end
endmodule

// File: tb/tb_top_control.sv
// tb_top_control: directed vectors for top_control. Observed word packs
// {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Operation, Illegal}.
module tb_top_control;
    logic clk;
    logic rst_n;

    top_control_if bus ();

    top_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    int unsigned vec_count;
    int unsigned err_count;

    logic [10:0] obs;
    assign obs = {bus.Branch, bus.MemRead, bus.MemtoReg, bus.MemWrite,
                  bus.ALUSrc, bus.RegWrite, bus.Operation, bus.Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [10:0] got,
                             input logic [10:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: observed %b, expected %b", tag, got, exp);
        end
    endtask

    // Change inputs away from the edge, then check just after the next edge
    task automatic step(input logic [6:0] op, input logic [3:0] fn,
                        input string tag, input logic [10:0] exp);
        @(negedge clk);
        bus.Opcode = op;
        bus.Funct  = fn;
        @(posedge clk);
        #1;
        check_vec(tag, obs, exp);
    endtask

    localparam logic [10:0] ZERO   = 11'b000000_0000_0;
    localparam logic [10:0] R_ADD  = 11'b000001_0010_0;
    localparam logic [10:0] R_SUB  = 11'b000001_0110_0;
    localparam logic [10:0] R_AND  = 11'b000001_0000_0;
    localparam logic [10:0] R_OR   = 11'b000001_0001_0;
    localparam logic [10:0] LOAD   = 11'b011011_0010_0;
    localparam logic [10:0] STORE  = 11'b000110_0010_0;
    localparam logic [10:0] BRANCH = 11'b100000_0110_0;
    localparam logic [10:0] ILL    = 11'b000000_0000_1;
`ifdef TOP_CONTROL_ITYPE_EN
    localparam logic [10:0] I_AND  = 11'b000011_0000_0;
    localparam logic [10:0] I_ADD  = 11'b000011_0010_0;
`else
    localparam logic [10:0] I_AND  = ILL;
    localparam logic [10:0] I_ADD  = ILL;
`endif

    initial begin
        vec_count  = 0;
        err_count  = 0;
        rst_n      = 1'b0;
        bus.Opcode = 7'b0110011;
        bus.Funct  = 4'b0000;

        // Reset held across several edges with a legal R-type on the bus
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_hold", obs, ZERO);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("reset_release_no_edge", obs, ZERO);
        @(posedge clk);
        #1;
        check_vec("reset_release", obs, R_ADD);

        // R-type sweep, one Funct change per cycle
        step(7'b0110011, 4'b0000, "r_add", R_ADD);
        step(7'b0110011, 4'b1000, "r_sub", R_SUB);
        step(7'b0110011, 4'b0111, "r_and", R_AND);
        step(7'b0110011, 4'b0110, "r_or",  R_OR);

        // Input change must not reach the outputs before the edge
        @(negedge clk);
        bus.Funct = 4'b1000;
        #1;
        check_vec("latency_hold", obs, R_OR);
        @(posedge clk);
        #1;
        check_vec("latency_update", obs, R_SUB);

        step(7'b0110011, 4'b0001, "r_other_funct", R_ADD);
        step(7'b0110011, 4'b1111, "r_other_funct2", R_ADD);

        // Memory and branch classes; Funct is don't-care here
        step(7'b0000011, 4'b1000, "load",   LOAD);
        step(7'b0100011, 4'b0111, "store",  STORE);
        step(7'b1100011, 4'b0110, "branch", BRANCH);
        step(7'b1100011, 4'b0000, "branch_f0", BRANCH);

        // Illegal opcodes
        step(7'b1111111, 4'b0110, "illegal_7f", ILL);
        step(7'b0000000, 4'b1000, "illegal_00", ILL);
        step(7'b0110111, 4'b0000, "illegal_lui", ILL);

        // I-type (legal only with the optional feature)
        step(7'b0010011, 4'b1111, "itype_and", I_AND);
        step(7'b0010011, 4'b0000, "itype_add", I_ADD);

        // Recovery to legal after illegal
        step(7'b0110011, 4'b0111, "r_after_illegal", R_AND);

        // Asynchronous reset between edges while decoding a load
        step(7'b0000011, 4'b0000, "load_pre_reset", LOAD);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset_clear", obs, ZERO);
        @(posedge clk);
        #1;
        check_vec("edge_during_reset", obs, ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_vec("load_after_reset", obs, LOAD);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
